msadc_spi_link: RTL and testbench

MSADC_SPI_LINK -- requirements
Module: msadc_spi_link

---
 rtl/msadc_spi_link_if.sv | 25 ++
 rtl/msadc_spi_link.sv | 214 +++++++++++++++++++++
 tb/tb_msadc_spi_link.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msadc_spi_link_if.sv
// Bus bundle for msadc_spi_link: SPI slave pins, result-frame handshake and config word output.
interface msadc_spi_link_if #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 7
);
    logic                          sck;
    logic                          cs;
    logic                          mosi;
    logic                          miso;
    logic [(N_WORDS-1)*WORD_W-1:0] res_data;
    logic                          res_valid;
    logic                          res_ready;
    logic [WORD_W-1:0]             cfg_data;
    logic                          cfg_valid;

    modport master (
        output sck, cs, mosi, res_data, res_valid,
        input  miso, res_ready, cfg_data, cfg_valid
    );

    modport slave (
        input  sck, cs, mosi, res_data, res_valid,
        output miso, res_ready, cfg_data, cfg_valid
    );
endinterface

// File: rtl/msadc_spi_link.sv
// SPI slave that streams buffered ADC result frames (status word + data words) and captures a config word.
// Optional feature: define MSADC_SPI_CRC_EN to append a CRC-8 (poly 0x07) after the data words.
module msadc_spi_link #(
    parameter int WORD_W     = 32,
    parameter int N_WORDS    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    msadc_spi_link_if.slave  bus
);
    localparam int DATA_LEN = N_WORDS * WORD_W;
    localparam int RES_W    = (N_WORDS - 1) * WORD_W;
`ifdef MSADC_SPI_CRC_EN
    localparam int FRAME_LEN = DATA_LEN + 8;
`else
    localparam int FRAME_LEN = DATA_LEN;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);
    localparam logic [LVL_W-1:0] DEPTH_C     = LVL_W'(FIFO_DEPTH);
`ifdef MSADC_SPI_CRC_EN
    localparam logic [CNT_W-1:0] DATA_LEN_C  = CNT_W'(DATA_LEN);

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [2:0]          r_sck_sync;
    logic [2:0]          r_cs_sync;
    logic [1:0]          r_mosi_sync;
    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_LEN-1:0] r_tx;
    logic [WORD_W-1:0]   r_rx;
    logic [WORD_W-1:0]   r_cfg_data;
    logic                r_cfg_valid;
`ifdef MSADC_SPI_CRC_EN
    logic [7:0]          r_crc;
`endif
    logic [RES_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_res_ready;

    logic                w_sck_rise;
    logic                w_sck_fall;
    logic                w_cs_fall;
    logic                w_cs_rise;
    logic                w_nonempty;
    logic                w_push;
    logic                w_commit;
    logic                w_pop;
    logic [LVL_W-1:0]    w_count_next;
    logic [WORD_W-1:0]   w_status;
    logic [DATA_LEN-1:0] w_frame;

    // Synchronisers; reset to 0 so a cs held low across reset never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= 3'b000;
            r_cs_sync   <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], bus.sck};
            r_cs_sync   <= {r_cs_sync[1:0], bus.cs};
            r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
        end
    end

    // Edge strobes, frame image and FIFO bookkeeping terms.
    always_comb begin
        w_sck_rise         = r_sck_sync[1] & ~r_sck_sync[2];
        w_sck_fall         = ~r_sck_sync[1] & r_sck_sync[2];
        w_cs_fall          = ~r_cs_sync[1] & r_cs_sync[2];
        w_cs_rise          = r_cs_sync[1] & ~r_cs_sync[2];
        w_nonempty         = (r_count != '0);
        w_push             = bus.res_valid & r_res_ready;
        w_commit           = (r_state == ST_DONE) && (r_bit_cnt == FRAME_LEN_C);
        w_pop              = w_commit & w_nonempty;
        w_count_next       = r_count + LVL_W'(w_push) - LVL_W'(w_pop);
        w_status           = '0;
        w_status[WORD_W-1] = w_nonempty;
        w_status[WORD_W-2] = r_ovf;
        w_status[4:0]      = 5'(r_count);
        w_frame            = {w_status, (w_nonempty ? r_mem[r_rd_ptr] : {RES_W{1'b0}})};
    end

    // Frame FSM: LOAD snapshots the head, SHIFT moves bits, DONE commits or abandons the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_cfg_data  <= '0;
            r_cfg_valid <= 1'b0;
`ifdef MSADC_SPI_CRC_EN
            r_crc       <= 8'h00;
`endif
        end else begin
            r_cfg_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_tx      <= w_frame;
                    r_bit_cnt <= '0;
                    r_rx      <= '0;
`ifdef MSADC_SPI_CRC_EN
                    r_crc     <= 8'h00;
`endif
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_sck_rise && (r_bit_cnt != FRAME_LEN_C)) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt < WORD_W_C) begin
                            r_rx <= {r_rx[WORD_W-2:0], r_mosi_sync[1]};
                        end
`ifdef MSADC_SPI_CRC_EN
                        if (r_bit_cnt < DATA_LEN_C) begin
                            r_crc <= crc8_step(r_crc, r_tx[DATA_LEN-1]);
                        end
`endif
                    end
                    // Zero fill keeps miso low once the frame has been exhausted.
                    if (w_sck_fall) begin
`ifdef MSADC_SPI_CRC_EN
                        if (r_bit_cnt == DATA_LEN_C) begin
                            r_tx <= {r_crc, {(DATA_LEN-8){1'b0}}};
                        end else begin
                            r_tx <= {r_tx[DATA_LEN-2:0], 1'b0};
                        end
`else
                        r_tx <= {r_tx[DATA_LEN-2:0], 1'b0};
`endif
                    end
                    if (w_cs_rise) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_bit_cnt >= WORD_W_C) begin
                        r_cfg_data  <= r_rx;
                        r_cfg_valid <= 1'b1;
                    end
                    r_tx      <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result FIFO pointers, level, overflow sticky and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_res_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_res_ready <= (w_count_next != DEPTH_C);
            if (bus.res_valid && !r_res_ready) begin
                r_ovf <= 1'b1;
            end else if (w_commit) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.res_data;
        end
    end

    assign bus.miso      = r_tx[DATA_LEN-1];
    assign bus.res_ready = r_res_ready;
    assign bus.cfg_data  = r_cfg_data;
    assign bus.cfg_valid = r_cfg_valid;
endmodule

// File: tb/tb_msadc_spi_link.sv
// Self-checking bench for msadc_spi_link: directed table, hand-written corner sequences and
// randomized traffic compared against a transaction-level queue model of the result link.
module tb_msadc_spi_link;
    localparam int W     = 32;
    localparam int NW    = 7;
    localparam int DEPTH = 4;
    localparam int DL    = NW * W;
    localparam int RW    = (NW - 1) * W;
`ifdef MSADC_SPI_CRC_EN
    localparam int FL = DL + 8;
`else
    localparam int FL = DL;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msadc_spi_link_if #(.WORD_W(W), .N_WORDS(NW)) bus ();

    msadc_spi_link #(.WORD_W(W), .N_WORDS(NW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          n_push;
        int          nbits;
        logic [W-1:0] mosi;
        logic [W-1:0] exp_w0;
        logic [W-1:0] exp_cfg;
    } vec_t;

    logic [RW-1:0] m_q[$];
    logic          m_ovf;
    logic [W-1:0]  m_cfg;
    int            errors   = 0;
    int            checks   = 0;
    int            cfg_seen = 0;
    int            push_seq = 0;

    always @(negedge clk) begin
        if (bus.cfg_valid === 1'b1) cfg_seen++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    function automatic logic [RW-1:0] rand_res();
        logic [RW-1:0] d;
        for (int i = 0; i < NW - 1; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    // Expected miso frame from the model state: status word, head data (or zeros), optional CRC.
    function automatic logic [FL-1:0] model_frame();
        logic [W-1:0]  st;
        logic [RW-1:0] d;
        logic [DL-1:0] f;
        st = '0;
        st[W-1] = (m_q.size() != 0);
        st[W-2] = m_ovf;
        st[4:0] = 5'(m_q.size());
        d = (m_q.size() != 0) ? m_q[0] : '0;
        f = {st, d};
`ifdef MSADC_SPI_CRC_EN
        begin
            logic [7:0] c;
            logic       fb;
            c = 8'h00;
            for (int i = DL - 1; i >= 0; i--) begin
                fb = c[7] ^ f[i];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
            return {f, c};
        end
`else
        return f;
`endif
    endfunction

    task automatic push_entry(input logic [RW-1:0] d);
        int t;
        t = 0;
        @(negedge clk);
        bus.res_data  = d;
        bus.res_valid = 1'b1;
        while (!bus.res_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!bus.res_ready) begin
            errors++;
            $display("FAIL push_timeout: res_ready got 0 expected 1");
        end else begin
            m_q.push_back(d);
        end
        push_seq++;
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic push_drop(input logic [RW-1:0] d);
        @(negedge clk);
        chk("full res_ready", 256'(bus.res_ready), 256'(0));
        bus.res_data  = d;
        bus.res_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.res_valid = 1'b0;
        m_ovf = 1'b1;
    endtask

    task automatic sck_bit(input logic m, output logic s);
        bus.mosi = m;
        repeat (2) @(negedge clk);
        s = bus.miso;
        bus.sck = 1'b1;
        repeat (4) @(negedge clk);
        bus.sck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input int nbits, input logic [W-1:0] mw, output logic [FL-1:0] got,
                             output int pulses, output int first_at);
        logic s;
        got = '0;
        pulses = 0;
        first_at = -1;
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            sck_bit((b < W) ? mw[W-1-b] : 1'($urandom_range(0, 1)), s);
            got = {got[FL-2:0], s};
        end
        bus.mosi = 1'b0;
        bus.cs   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.cfg_valid) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
    endtask

    task automatic do_frame(input string tag, input int nbits, input logic [W-1:0] mw,
                            output logic [FL-1:0] got);
        logic [FL-1:0] expf;
        int pulses, first_at;
        expf = model_frame();
        run_frame(nbits, mw, got, pulses, first_at);
        chk({tag, " frame"}, 256'(got), 256'(expf >> (FL - nbits)));
        if (nbits >= FL) begin
            if (m_q.size() != 0) void'(m_q.pop_front());
            m_ovf = 1'b0;
        end
        if (nbits >= W) m_cfg = mw;
        chk({tag, " cfg_pulses"}, 256'(pulses), (nbits >= W) ? 256'(1) : 256'(0));
        if (nbits >= W) begin
            checks++;
            if (first_at < 3 || first_at > 5) begin
                errors++;
                $display("FAIL %s cfg_latency: got %0d clk expected 3..5", tag, first_at);
            end
        end
        chk({tag, " cfg_data"}, 256'(bus.cfg_data), 256'(m_cfg));
    endtask

    task automatic check_w0(input string nm, input logic [FL-1:0] got, input int nbits,
                            input logic [W-1:0] expw);
        logic [FL-1:0] gal;
        logic [W-1:0]  mask;
        int n;
        n    = (nbits < W) ? nbits : W;
        gal  = got << (FL - nbits);
        mask = '1;
        mask = mask << (W - n);
        chk({nm, " word0"}, 256'(gal[FL-1 -: W] & mask), 256'(expw & mask));
    endtask

    vec_t          tbl[10];
    logic [RW-1:0] std_pat;
    logic [FL-1:0] got;
    logic          s, acc;
    int            c0, np, nb;

    initial begin
        std_pat = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        tbl[0] = '{0, FL,     32'h12345678, 32'h00000000, 32'h12345678};
        tbl[1] = '{1, FL,     32'hA8010000, 32'h80000001, 32'hA8010000};
        tbl[2] = '{0, FL,     32'h00000000, 32'h00000000, 32'h00000000};
        tbl[3] = '{1, 20,     32'hFFFFFFFF, 32'h80000001, 32'h00000000};
        tbl[4] = '{0, FL,     32'h0F0F0F0F, 32'h80000001, 32'h0F0F0F0F};
        tbl[5] = '{2, 31,     32'h00000001, 32'h80000002, 32'h0F0F0F0F};
        tbl[6] = '{0, 32,     32'hCAFEBABE, 32'h80000002, 32'hCAFEBABE};
        tbl[7] = '{0, FL - 1, 32'h5A5A5A5A, 32'h80000002, 32'h5A5A5A5A};
        tbl[8] = '{0, FL,     32'h13579BDF, 32'h80000002, 32'h13579BDF};
        tbl[9] = '{0, FL,     32'h2468ACE0, 32'h80000001, 32'h2468ACE0};

        bus.sck = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
        bus.res_data = '0; bus.res_valid = 1'b0;
        m_ovf = 1'b0; m_cfg = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset miso", 256'(bus.miso), 256'(0));
        chk("reset res_ready", 256'(bus.res_ready), 256'(1));
        chk("reset cfg_valid", 256'(bus.cfg_valid), 256'(0));
        chk("reset cfg_data", 256'(bus.cfg_data), 256'(0));

        // Directed table
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n_push; k++) push_entry((push_seq == 0) ? std_pat : rand_res());
            do_frame($sformatf("vec%0d", i), tbl[i].nbits, tbl[i].mosi, got);
            check_w0($sformatf("vec%0d", i), got, tbl[i].nbits, tbl[i].exp_w0);
            chk($sformatf("vec%0d cfg_const", i), 256'(bus.cfg_data), 256'(tbl[i].exp_cfg));
        end

        // Overflow: five offered, four accepted, sticky reported then cleared
        for (int k = 0; k < DEPTH; k++) push_entry(rand_res());
        push_drop(rand_res());
        do_frame("ovf1", FL, 32'h0, got);
        check_w0("ovf1", got, FL, 32'hC0000004);
        do_frame("ovf2", FL, 32'h0, got);
        check_w0("ovf2", got, FL, 32'h80000003);

        // Reset in mid-frame with cs held low
        c0 = cfg_seen;
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 100; b++) sck_bit(1'($urandom_range(0, 1)), s);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_q.delete(); m_ovf = 1'b0; m_cfg = '0;
        chk("midrst miso", 256'(bus.miso), 256'(0));
        chk("midrst res_ready", 256'(bus.res_ready), 256'(1));
        chk("midrst cfg_valid", 256'(bus.cfg_valid), 256'(0));
        chk("midrst cfg_data", 256'(bus.cfg_data), 256'(0));
        push_entry(rand_res());
        acc = 1'b0;
        for (int b = 0; b < 40; b++) begin
            sck_bit(1'b1, s);
            acc = acc | s;
        end
        chk("cs_low_after_rst miso", 256'(acc), 256'(0));
        chk("cs_low_after_rst cfg_pulses", 256'(cfg_seen - c0), 256'(0));
        @(negedge clk);
        bus.cs = 1'b1;
        repeat (5) @(negedge clk);
        do_frame("after_rst", FL, 32'h600DF00D, got);
        check_w0("after_rst", got, FL, 32'h80000001);

        // Randomized traffic against the model
        for (int it = 0; it < 8; it++) begin
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) begin
                if (m_q.size() < DEPTH) push_entry(rand_res());
                else push_drop(rand_res());
            end
            nb = ($urandom_range(0, 2) != 0) ? FL : $urandom_range(1, FL - 1);
            do_frame($sformatf("rand%0d", it), nb, $urandom, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
